// File: rtl/cdma_despreader_if.sv
// Chip-stream and decision bundle between a chip source and the CDMA despreader.
// The despreader connects via the slave modport, the chip source via master.
interface cdma_despreader_if #(
    parameter int unsigned CNT_W = 5
);
    logic             chip_i;
    logic             code_i;
    logic             chip_valid_i;
    logic             sync_i;
    logic             bit_o;
    logic             bit_valid_o;
    logic [CNT_W-1:0] match_o;
    logic             err_o;
    logic             slip_o;
    logic             lock_o;

    modport master (
        output chip_i, code_i, chip_valid_i, sync_i,
        input  bit_o, bit_valid_o, match_o, err_o, slip_o, lock_o
    );

    modport slave (
        input  chip_i, code_i, chip_valid_i, sync_i,
        output bit_o, bit_valid_o, match_o, err_o, slip_o, lock_o
    );
endinterface

// File: rtl/cdma_despreader.sv
// CDMA despreader: correlates received chips against the local Gold code per code
// period and issues a hard bit decision, an ambiguity flag and a lock indicator.
module cdma_despreader #(
    parameter int unsigned CODE_LEN = 31,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned THRESH   = 24,
    parameter int unsigned LOCK_N   = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    cdma_despreader_if.slave bus
);
    localparam int unsigned      LockW   = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CODE_LEN - 1);
    localparam logic [CNT_W-1:0] HiThr   = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] LoThr   = CNT_W'(CODE_LEN - THRESH);
    localparam logic [CNT_W-1:0] Half    = CNT_W'(CODE_LEN / 2);
    localparam logic [LockW-1:0] LockMax = LockW'(LOCK_N);

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_idx, w_idx_nxt;
    logic [CNT_W-1:0] r_acc, w_acc_nxt;
    logic [LockW-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic             r_bit, w_bit_nxt;
    logic             r_bit_valid, w_bit_valid_nxt;
    logic [CNT_W-1:0] r_match, w_match_nxt;
    logic             r_err, w_err_nxt;
    logic             r_slip, w_slip_nxt;

    logic             w_match_bit;
    logic [CNT_W-1:0] w_total;
    logic [LockW-1:0] w_lock_inc;

    assign w_match_bit = ~(bus.chip_i ^ bus.code_i);
    assign w_total     = r_acc + CNT_W'(w_match_bit);
    assign w_lock_inc  = (r_lock_cnt == LockMax) ? LockMax : r_lock_cnt + LockW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_acc_nxt       = r_acc;
        w_lock_cnt_nxt  = r_lock_cnt;
        w_bit_nxt       = r_bit;
        w_match_nxt     = r_match;
        w_bit_valid_nxt = 1'b0;
        w_err_nxt       = 1'b0;
        w_slip_nxt      = 1'b0;
        if (bus.chip_valid_i) begin
            unique case (r_state)
                StIdle: begin
                    if (bus.sync_i) begin
                        w_state_nxt = StAccum;
                        w_idx_nxt   = CNT_W'(1);
                        w_acc_nxt   = CNT_W'(w_match_bit);
                    end
                end
                StAccum: begin
                    if (bus.sync_i && (r_idx != '0)) begin
                        // Misaligned sync restarts the period at this chip.
                        w_idx_nxt      = CNT_W'(1);
                        w_acc_nxt      = CNT_W'(w_match_bit);
                        w_slip_nxt     = 1'b1;
                        w_lock_cnt_nxt = '0;
                    end else if (r_idx == LastIdx) begin
                        w_idx_nxt       = '0;
                        w_acc_nxt       = '0;
                        w_bit_valid_nxt = 1'b1;
                        w_match_nxt     = w_total;
                        if (w_total >= HiThr) begin
                            w_bit_nxt      = 1'b0;
                            w_lock_cnt_nxt = w_lock_inc;
                        end else if (w_total <= LoThr) begin
                            w_bit_nxt      = 1'b1;
                            w_lock_cnt_nxt = w_lock_inc;
                        end else begin
                            w_err_nxt      = 1'b1;
                            w_bit_nxt      = ~(w_total > Half);
                            w_lock_cnt_nxt = '0;
                        end
                    end else begin
                        w_idx_nxt = r_idx + CNT_W'(1);
                        w_acc_nxt = w_total;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_acc       <= '0;
            r_lock_cnt  <= '0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_match     <= '0;
            r_err       <= 1'b0;
            r_slip      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_acc       <= w_acc_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_bit_valid <= w_bit_valid_nxt;
            r_match     <= w_match_nxt;
            r_err       <= w_err_nxt;
            r_slip      <= w_slip_nxt;
        end
    end

    assign bus.bit_o       = r_bit;
    assign bus.bit_valid_o = r_bit_valid;
    assign bus.match_o     = r_match;
    assign bus.err_o       = r_err;
    assign bus.slip_o      = r_slip;
    assign bus.lock_o      = (r_lock_cnt == LockMax);
endmodule

// File: tb/tb_cdma_despreader.sv
// Self-checking bench for cdma_despreader: random chip streams compared cycle by cycle
// against a queue-based period model, plus directed scenario checks.
module tb_cdma_despreader;
    localparam int CODE_LEN = 31;
    localparam int CNT_W    = 5;
    localparam int THRESH   = 24;
    localparam int LOCK_N   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdma_despreader_if #(.CNT_W(CNT_W)) bus ();

    cdma_despreader #(
        .CODE_LEN(CODE_LEN),
        .CNT_W   (CNT_W),
        .THRESH  (THRESH),
        .LOCK_N  (LOCK_N)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: match bits of the current period held in a queue.
    int q[$];
    bit synced   = 1'b0;
    int lock_cnt = 0;
    bit exp_bit = 1'b0, exp_bv = 1'b0, exp_err = 1'b0, exp_slip = 1'b0;
    int exp_match = 0;

    // Observation tallies.
    int n_bv, n_slip, cyc_mism;
    bit d_bit, d_err, d_lock;
    int d_match;

    task automatic model_step(input bit r, input bit v, input bit c, input bit k, input bit s);
        int m;
        int total;
        exp_bv   = 1'b0;
        exp_err  = 1'b0;
        exp_slip = 1'b0;
        if (r) begin
            q.delete();
            synced    = 1'b0;
            lock_cnt  = 0;
            exp_bit   = 1'b0;
            exp_match = 0;
        end else if (v) begin
            m = (c == k) ? 1 : 0;
            if (!synced) begin
                if (s) begin
                    synced = 1'b1;
                    q.delete();
                    q.push_back(m);
                end
            end else if (s && q.size() != 0) begin
                exp_slip = 1'b1;
                lock_cnt = 0;
                q.delete();
                q.push_back(m);
            end else begin
                q.push_back(m);
                if (q.size() == CODE_LEN) begin
                    total = 0;
                    foreach (q[i]) total += q[i];
                    q.delete();
                    exp_bv    = 1'b1;
                    exp_match = total;
                    if (total >= THRESH) begin
                        exp_bit  = 1'b0;
                        lock_cnt = (lock_cnt < LOCK_N) ? lock_cnt + 1 : LOCK_N;
                    end else if (total <= CODE_LEN - THRESH) begin
                        exp_bit  = 1'b1;
                        lock_cnt = (lock_cnt < LOCK_N) ? lock_cnt + 1 : LOCK_N;
                    end else begin
                        exp_err  = 1'b1;
                        exp_bit  = (total > CODE_LEN / 2) ? 1'b0 : 1'b1;
                        lock_cnt = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit c, input bit k, input bit s);
        bit exp_lock;
        rst              = r;
        bus.chip_valid_i = v;
        bus.chip_i       = c;
        bus.code_i       = k;
        bus.sync_i       = s;
        @(posedge clk);
        #1;
        model_step(r, v, c, k, s);
        exp_lock = (lock_cnt == LOCK_N);
        if (bus.bit_valid_o !== exp_bv || bus.bit_o !== exp_bit ||
            bus.match_o !== CNT_W'(exp_match) || bus.err_o !== exp_err ||
            bus.slip_o !== exp_slip || bus.lock_o !== exp_lock)
            cyc_mism++;
        if (bus.bit_valid_o === 1'b1) begin
            n_bv++;
            d_bit   = bus.bit_o;
            d_match = int'(bus.match_o);
            d_err   = bus.err_o;
            d_lock  = bus.lock_o;
        end
        if (bus.slip_o === 1'b1) n_slip++;
    endtask

    task automatic clear_tally();
        n_bv = 0; n_slip = 0; cyc_mism = 0;
        d_bit = 1'b0; d_err = 1'b0; d_lock = 1'b0; d_match = -1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic idle_gap(input int maxg);
        repeat ($urandom_range(0, maxg)) cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic clean_chip(input bit s);
        bit k;
        k = 1'($urandom);
        cycle(1'b0, 1'b1, k, k, s);
    endtask

    // One full period carrying data bit 'data' with 'flips' corrupted chips.
    task automatic period(input bit data, input int flips, input bit sync_first, input int maxg);
        bit fl[CODE_LEN];
        int placed;
        bit k;
        foreach (fl[i]) fl[i] = 1'b0;
        placed = 0;
        while (placed < flips) begin
            int p;
            p = $urandom_range(0, CODE_LEN - 1);
            if (!fl[p]) begin
                fl[p] = 1'b1;
                placed++;
            end
        end
        for (int i = 0; i < CODE_LEN; i++) begin
            idle_gap(maxg);
            k = 1'($urandom);
            cycle(1'b0, 1'b1, k ^ data ^ fl[i], k, sync_first && (i == 0));
        end
    endtask

    task automatic test_reset();
        clear_tally();
        do_reset(2);
        if (bus.bit_o !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b want 0", bus.bit_o); end
        checks++;
        if (bus.bit_valid_o !== 1'b0) begin errors++; $display("FAIL reset_bv: got %b want 0", bus.bit_valid_o); end
        checks++;
        if (bus.match_o !== '0) begin errors++; $display("FAIL reset_match: got %0d want 0", bus.match_o); end
        checks++;
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        checks++;
        if (bus.slip_o !== 1'b0) begin errors++; $display("FAIL reset_slip: got %b want 0", bus.slip_o); end
        checks++;
        if (bus.lock_o !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b want 0", bus.lock_o); end
        checks++;
        repeat (40) begin
            bit k;
            k = 1'($urandom);
            cycle(1'b0, 1'b1, k, k, 1'b0);
        end
        if (n_bv !== 0) begin errors++; $display("FAIL idle_no_sync_bv: got %0d pulses want 0", n_bv); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL reset_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_data0();
        clear_tally();
        period(1'b0, 0, 1'b1, 0);
        if (n_bv !== 1) begin errors++; $display("FAIL data0_bv: got %0d pulses want 1", n_bv); end
        checks++;
        if (d_bit !== 1'b0) begin errors++; $display("FAIL data0_bit: got %b want 0", d_bit); end
        checks++;
        if (d_match !== 31) begin errors++; $display("FAIL data0_match: got %0d want 31", d_match); end
        checks++;
        if (d_err !== 1'b0) begin errors++; $display("FAIL data0_err: got %b want 0", d_err); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL data0_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_data1_noise();
        clear_tally();
        period(1'b1, 5, 1'b1, 0);
        if (d_bit !== 1'b1) begin errors++; $display("FAIL data1_bit: got %b want 1", d_bit); end
        checks++;
        if (d_match !== 5) begin errors++; $display("FAIL data1_match: got %0d want 5", d_match); end
        checks++;
        if (d_err !== 1'b0) begin errors++; $display("FAIL data1_err: got %b want 0", d_err); end
        checks++;
        clear_tally();
        period(1'b0, 10, 1'b1, 0);
        if (d_match !== 21) begin errors++; $display("FAIL noisy_match: got %0d want 21", d_match); end
        checks++;
        if (d_err !== 1'b1) begin errors++; $display("FAIL noisy_err: got %b want 1", d_err); end
        checks++;
        if (d_bit !== 1'b0) begin errors++; $display("FAIL noisy_bit: got %b want 0", d_bit); end
        checks++;
        if (d_lock !== 1'b0) begin errors++; $display("FAIL noisy_lock: got %b want 0", d_lock); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL noise_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_lock_gaps();
        do_reset(1);
        for (int p = 0; p < 3; p++) begin
            clear_tally();
            period(1'b0, 0, p == 0, 3);
            if (d_lock !== (p == 2)) begin
                errors++;
                $display("FAIL lock_period%0d: got %b want %b", p, d_lock, p == 2);
            end
            checks++;
            if (cyc_mism !== 0) begin
                errors++;
                $display("FAIL lock_cycles%0d: got %0d mismatched cycles want 0", p, cyc_mism);
            end
            checks++;
        end
        clear_tally();
        period(1'b0, 16, 1'b0, 3);
        if (d_match !== 15) begin errors++; $display("FAIL amb_match: got %0d want 15", d_match); end
        checks++;
        if (d_err !== 1'b1) begin errors++; $display("FAIL amb_err: got %b want 1", d_err); end
        checks++;
        if (d_bit !== 1'b1) begin errors++; $display("FAIL amb_bit: got %b want 1", d_bit); end
        checks++;
        if (d_lock !== 1'b0) begin errors++; $display("FAIL amb_lock_fall: got %b want 0", d_lock); end
        checks++;
    endtask

    task automatic test_slip();
        do_reset(1);
        period(1'b0, 0, 1'b1, 1);
        period(1'b0, 0, 1'b0, 1);
        period(1'b0, 0, 1'b0, 1);
        clear_tally();
        for (int i = 0; i < 10; i++) clean_chip(i == 0);
        clean_chip(1'b1);
        if (n_slip !== 1) begin errors++; $display("FAIL slip_pulse: got %0d pulses want 1", n_slip); end
        checks++;
        if (bus.lock_o !== 1'b0) begin errors++; $display("FAIL slip_lock: got %b want 0", bus.lock_o); end
        checks++;
        for (int i = 0; i < 29; i++) clean_chip(1'b0);
        if (n_bv !== 0) begin errors++; $display("FAIL slip_no_decision: got %0d pulses want 0", n_bv); end
        checks++;
        clean_chip(1'b0);
        if (n_bv !== 1) begin errors++; $display("FAIL slip_realign_bv: got %0d pulses want 1", n_bv); end
        checks++;
        if (d_match !== 31) begin errors++; $display("FAIL slip_realign_match: got %0d want 31", d_match); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL slip_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_sync_edges();
        clear_tally();
        for (int i = 0; i < CODE_LEN - 1; i++) clean_chip(1'b0);
        clean_chip(1'b1);
        if (n_slip !== 1) begin errors++; $display("FAIL last_chip_sync_slip: got %0d want 1", n_slip); end
        checks++;
        if (n_bv !== 0) begin errors++; $display("FAIL last_chip_sync_bv: got %0d want 0", n_bv); end
        checks++;
        for (int i = 0; i < CODE_LEN - 1; i++) clean_chip(1'b0);
        if (n_bv !== 1) begin errors++; $display("FAIL last_chip_sync_realign: got %0d want 1", n_bv); end
        checks++;
        clear_tally();
        period(1'b0, 0, 1'b1, 0);
        if (n_slip !== 0) begin errors++; $display("FAIL sync_after_end_slip: got %0d want 0", n_slip); end
        checks++;
        if (n_bv !== 1) begin errors++; $display("FAIL sync_after_end_bv: got %0d want 1", n_bv); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL sync_edge_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_reset_mid();
        bit k;
        clear_tally();
        for (int i = 0; i < 17; i++) clean_chip(i == 0);
        k = 1'($urandom);
        cycle(1'b1, 1'b1, k, k, 1'b0);
        if ({bus.bit_o, bus.bit_valid_o, bus.err_o, bus.slip_o, bus.lock_o} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %b want 00000",
                     {bus.bit_o, bus.bit_valid_o, bus.err_o, bus.slip_o, bus.lock_o});
        end
        checks++;
        if (bus.match_o !== '0) begin errors++; $display("FAIL midreset_match: got %0d want 0", bus.match_o); end
        checks++;
        clear_tally();
        period(1'b0, 0, 1'b1, 2);
        if (n_bv !== 1) begin errors++; $display("FAIL midreset_bv: got %0d want 1", n_bv); end
        checks++;
        if (d_match !== 31) begin errors++; $display("FAIL midreset_match31: got %0d want 31", d_match); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL midreset_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    task automatic test_random();
        clear_tally();
        for (int p = 0; p < 8; p++)
            period(1'($urandom), $urandom_range(0, CODE_LEN), p == 0, 2);
        if (n_bv !== 8) begin errors++; $display("FAIL random_bv: got %0d want 8", n_bv); end
        checks++;
        if (cyc_mism !== 0) begin errors++; $display("FAIL random_cycles: got %0d mismatched cycles want 0", cyc_mism); end
        checks++;
    endtask

    initial begin
        rst              = 1'b1;
        bus.chip_valid_i = 1'b0;
        bus.chip_i       = 1'b0;
        bus.code_i       = 1'b0;
        bus.sync_i       = 1'b0;
        test_reset();
        test_data0();
        test_data1_noise();
        test_lock_gaps();
        test_slip();
        test_sync_edges();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdma_despreader.md
Name: cdma_despreader

Overview:
Receive-side stage that consumes the spread chip stream (`cdma_o`) produced by the `cdma` spreader and recovers the data bits.
- Each valid chip is compared against the locally generated Gold-code chip.
- Chip agreements are counted over one code period.
- At the end of the period the block issues a hard bit decision, a confidence flag and a lock indicator.
- The decoded bit feeds the receptor/LED logic in the top-level wrapper.

Parameters:
- `CODE_LEN`, default 31: chips per code period (Gold code from 5-bit LFSR pair); legal range 2..(2^`CNT_W` − 1).
- `CNT_W`, default 5: width of the chip index counter and the match counter.
- `THRESH`, default 24: minimum agreements for a confident decision. Legal range is `CODE_LEN/2` < `THRESH` <= `CODE_LEN`.
- `LOCK_N`, default 3: consecutive confident decisions required to assert lock.

Ports:
- `clk_i` input 1: single clock, all logic on rising edge.
- `rst_i` input 1: synchronous reset, active-high.
- `chip_i` input 1: received spread chip.
- `code_i` input 1: local Gold-code chip, aligned with `chip_i`.
- `chip_valid_i` input 1: qualifies `chip_i`/`code_i`/`sync_i`; chips are consumed only when high.
- `sync_i` input 1: marks the current valid chip as code-period index 0.
- `bit_o` output 1: decoded data bit; registered and held until the next decision.
- `bit_valid_o` output 1: one-cycle pulse, decision available.
- `match_o` output `CNT_W`: agreement count of the last completed period; held.
- `err_o` output 1: one-cycle pulse with `bit_valid_o` when the decision is ambiguous.
- `slip_o` output 1: one-cycle pulse on a sync misalignment.
- `lock_o` output 1: level, receiver locked.

Behaviour:
- Reset (`rst_i`=1 at a clock edge, including mid-period): state=IDLE; chip index, match accumulator and lock counter cleared. All outputs 0.
- States:
  - IDLE: valid chips without `sync_i` are ignored. A valid chip with `sync_i` is counted as index 0, then go to ACCUM.
  - ACCUM: on each valid chip, accumulator += (`chip_i` XNOR `code_i`) and index increments.
  - No change in any state when `chip_valid_i`=0; gaps of any length are allowed.
- Period end: the valid chip at index `CODE_LEN`−1 completes the period.
  - Next cycle (latency 1): `bit_valid_o`=1 and `match_o` = total matches including that last chip.
  - Same edge: index wraps to 0 and the accumulator clears. State stays ACCUM (free-running), so the next valid chip is index 0 with no new sync needed.
- Decision from match count M:
  - M >= `THRESH`: `bit_o`=0, `err_o`=0.
  - M <= `CODE_LEN`−`THRESH`: `bit_o`=1, `err_o`=0.
  - Otherwise (ambiguous): `err_o`=1 and `bit_o` = (M > `CODE_LEN`/2) ? 0 : 1.
- `sync_i` handling in ACCUM:
  - On a valid chip at index 0: consistent, no effect.
  - On a valid chip at any other index: the current period is aborted with no `bit_valid_o` for it. The chip is counted as index 0 of a new period (accumulator = its match bit).
  - The abort causes `slip_o` to pulse next cycle and the lock counter to clear.
- Lock:
  - Saturating counter 0..`LOCK_N`; increments on each confident decision.
  - Clears on ambiguous decision, slip or reset.
  - `lock_o`=1 while counter == `LOCK_N`. It rises in the same cycle as the `LOCK_N`-th confident `bit_valid_o` pulse and falls in the cycle of the clearing `err_o`/`slip_o` pulse.
- Simultaneous events:
  - `sync_i` on the chip right after a period end is index 0, so no slip.
  - `sync_i` coinciding with the last chip (index `CODE_LEN`−1) is a slip: the period is aborted with no decision.
- Outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
- Reset: assert `rst_i` 2 cycles → all outputs 0, IDLE. Valid chips without `sync_i` → no `bit_valid_o`.
- Data 0: sync, then 31 valid chips with `chip_i`=`code_i` (random code) → 1 cycle after chip 31: `bit_valid_o`=1, `bit_o`=0, `match_o`=31, `err_o`=0.
- Data 1 with noise:
  - `chip_i` = ~`code_i` with 5 chips flipped back → `bit_o`=1, `match_o`=5.
  - Repeat with 10 flips on a data-0 period → `match_o`=21, `err_o`=1, `bit_o`=0, `lock_o`=0.
- Lock and gaps: 3 clean periods with random `chip_valid_i` gaps → `lock_o` rises with the 3rd `bit_valid_o`. A 4th period with M=15 → `err_o`=1 and `lock_o` falls.
- Slip: while locked, assert `sync_i` at index 10 → no decision for that period, `slip_o` pulse, `lock_o`=0. The next decision arrives after 31 valid chips counted from that chip.
- Reset mid-period: `rst_i` at index 17 → outputs 0. A subsequent sync/31-chip period decodes correctly with `match_o`=31.
